multicycle_controller: RTL

Parametrised FSM control unit for the multi-cycle RV32I core, replacing the single-cycle combinational decoder. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB over one shared memory port with a req/ready handshake. It keeps the instruction register and traps on illegal encodings and memory timeouts. It also counts retired instructions. It drives the same datapath select encodings as the single-cycle core, plus multi-cycle strobes.

---
 rtl/multicycle_controller.sv | 325 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// FSM control unit for the multi-cycle RV32I core. Each instruction walks
// FETCH -> DECODE -> EXEC -> [MEM] -> WB over one shared memory port using a
// mem_req/mem_ready handshake. Illegal encodings and memory timeouts divert
// to TRAP, which redirects the PC to the trap vector.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   inst             memory read data, loaded into IR on a fetch handshake
//   mem_ready        memory completes the current request this cycle
//   BrEq, BrLt       branch comparator results
//   mem_req          memory request
//   MemRW            1 = read, 0 = write
//   IorD             address select: 0 = PC, 1 = ALU result
//   IRWrite, PCWrite IR / PC load strobes
//   PCSel            0 = PC+4, 1 = ALU, 2 = trap vector
//   RegWEn, BrUn,
//   ASel, BSel       datapath controls, single-cycle core encodings
//   WBSel            0 = mem, 1 = ALU, 2 = PC+4, 3 = imm
//   ImmSel           0 = S, 1 = I, 2 = B, 3 = J, 4 = U
//   ALUSel           ADD 0 .. AND 9
//   trap             one-cycle trap pulse
//   trap_cause       0 = illegal instruction, 1 = memory timeout (held)
//   ir               instruction register
//   instret          retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int nbit        = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [nbit-1:0]  inst,
    input  logic             mem_ready,
    input  logic             BrEq,
    input  logic             BrLt,
    output logic             mem_req,
    output logic             MemRW,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       PCSel,
    output logic             RegWEn,
    output logic             BrUn,
    output logic             ASel,
    output logic             BSel,
    output logic [1:0]       WBSel,
    output logic [2:0]       ImmSel,
    output logic [3:0]       ALUSel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [nbit-1:0]  ir,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] IMM_S = 3'd0, IMM_I = 3'd1, IMM_B = 3'd2,
                           IMM_J = 3'd3, IMM_U = 3'd4;
    localparam logic [1:0] WB_MEM = 2'd0, WB_ALU = 2'd1, WB_PC4 = 2'd2, WB_IMM = 2'd3;
    localparam logic [1:0] PC_PLUS4 = 2'd0, PC_ALU = 2'd1, PC_TRAP = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd0, CAUSE_TIMEOUT = 2'd1;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_OR = 4'd8, ALU_AND = 4'd9
    } alu_t;

    // The wait counter only needs to reach MEM_TIMEOUT-1; the wait cycle that
    // would bring it to MEM_TIMEOUT is the one that traps.
    localparam int              TMO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit              TMO_EN   = (MEM_TIMEOUT > 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           state_q;
    logic [nbit-1:0]  ir_q;
    logic [CNT_W-1:0] instret_q;
    logic [1:0]       trap_cause_q;
    logic [TMO_W-1:0] tmo_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];

    // -------------------------------------------------------------------------
    // Instruction decode from IR (stable from DECODE until the next fetch)
    // -------------------------------------------------------------------------
    function automatic alu_t alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic       dec_legal, dec_mem, dec_store, dec_branch, dec_jump;
    logic       dec_brun, dec_asel, dec_bsel;
    logic [1:0] dec_wbsel;
    logic [2:0] dec_immsel;
    alu_t       dec_alu;
    logic       br_taken;

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        dec_legal  = 1'b0;
        dec_mem    = 1'b0;
        dec_store  = 1'b0;
        dec_branch = 1'b0;
        dec_jump   = 1'b0;
        dec_brun   = 1'b0;
        dec_asel   = 1'b0;
        dec_bsel   = 1'b0;
        dec_wbsel  = WB_ALU;
        dec_immsel = IMM_S;
        dec_alu    = ALU_ADD;
        case (opcode)
            OPC_LUI: begin
                dec_legal  = 1'b1;
                dec_immsel = IMM_U;
                dec_bsel   = 1'b1;
                dec_wbsel  = WB_IMM;
            end
            OPC_AUIPC: begin
                dec_legal  = 1'b1;
                dec_immsel = IMM_U;
                dec_asel   = 1'b1;
                dec_bsel   = 1'b1;
            end
            OPC_JAL: begin
                dec_legal  = 1'b1;
                dec_jump   = 1'b1;
                dec_immsel = IMM_J;
                dec_asel   = 1'b1;
                dec_bsel   = 1'b1;
                dec_wbsel  = WB_PC4;
            end
            OPC_JALR: begin
                dec_legal  = (funct3 == 3'b000);
                dec_jump   = 1'b1;
                dec_immsel = IMM_I;
                dec_bsel   = 1'b1;
                dec_wbsel  = WB_PC4;
            end
            OPC_BRANCH: begin
                dec_legal  = (funct3 != 3'b010) && (funct3 != 3'b011);
                dec_branch = 1'b1;
                dec_brun   = funct3[2] & funct3[1];  // BLTU / BGEU
                dec_immsel = IMM_B;
                dec_asel   = 1'b1;
                dec_bsel   = 1'b1;
            end
            OPC_LOAD: begin
                dec_legal  = !((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111));
                dec_mem    = 1'b1;
                dec_immsel = IMM_I;
                dec_bsel   = 1'b1;
                dec_wbsel  = WB_MEM;
            end
            OPC_STORE: begin
                dec_legal  = (funct3 <= 3'b010);
                dec_mem    = 1'b1;
                dec_store  = 1'b1;
                dec_immsel = IMM_S;
                dec_bsel   = 1'b1;
            end
            OPC_OPIMM: begin
                case (funct3)
                    3'b001:  dec_legal = (funct7 == 7'h00);
                    3'b101:  dec_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                    default: dec_legal = 1'b1;
                endcase
                dec_immsel = IMM_I;
                dec_bsel   = 1'b1;
                // Bit 30 selects SRAI only; for ADDI it is part of the immediate.
                dec_alu    = alu_from_funct3(funct3, (funct3 == 3'b101) & funct7[5]);
            end
            OPC_OP: begin
                dec_legal = (funct7 == 7'h00) ||
                            ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                dec_alu   = alu_from_funct3(funct3, funct7[5]);
            end
            default: ;
        endcase
    end

    // funct3[2] picks the less-than comparator, funct3[0] inverts the sense.
    assign br_taken = funct3[0] ^ (funct3[2] ? BrLt : BrEq);

    // -------------------------------------------------------------------------
    // State, IR, retire counter, trap cause and memory wait counter
    // -------------------------------------------------------------------------
    logic tmo_hit;
    assign tmo_hit = TMO_EN && (tmo_q == TMO_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            ir_q         <= nbit'(32'h0000_0013);
            instret_q    <= '0;
            trap_cause_q <= CAUSE_ILLEGAL;
            tmo_q        <= '0;
        end else begin
            case (state_q)
                S_FETCH, S_MEM: begin
                    if (mem_ready) begin
                        tmo_q <= '0;
                        if (state_q == S_FETCH) begin
                            ir_q    <= inst;
                            state_q <= S_DECODE;
                        end else begin
                            state_q <= S_WB;
                        end
                    end else if (tmo_hit) begin
                        tmo_q        <= '0;
                        trap_cause_q <= CAUSE_TIMEOUT;
                        state_q      <= S_TRAP;
                    end else if (TMO_EN) begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (dec_legal) begin
                        state_q <= S_EXEC;
                    end else begin
                        trap_cause_q <= CAUSE_ILLEGAL;
                        state_q      <= S_TRAP;
                    end
                end
                S_EXEC:  state_q <= dec_mem ? S_MEM : S_WB;
                S_WB: begin
                    instret_q <= instret_q + 1'b1;
                    state_q   <= S_FETCH;
                end
                S_TRAP:  state_q <= S_FETCH;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded from state and IR. Gating with rst_n makes the strobes
    // drop the moment reset asserts rather than at the next edge.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_req = 1'b0;
        MemRW   = 1'b1;
        IorD    = 1'b0;
        IRWrite = 1'b0;
        PCWrite = 1'b0;
        PCSel   = PC_PLUS4;
        RegWEn  = 1'b0;
        BrUn    = 1'b0;
        ASel    = 1'b0;
        BSel    = 1'b0;
        WBSel   = WB_MEM;
        ImmSel  = IMM_S;
        ALUSel  = ALU_ADD;
        trap    = 1'b0;
        if (rst_n) begin
            if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
                BrUn   = dec_brun;
                ASel   = dec_asel;
                BSel   = dec_bsel;
                WBSel  = dec_wbsel;
                ImmSel = dec_immsel;
                ALUSel = dec_alu;
            end
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    IRWrite = mem_ready;
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    IorD    = 1'b1;
                    MemRW   = !dec_store;
                end
                S_WB: begin
                    PCWrite = 1'b1;
                    RegWEn  = !(dec_branch || dec_store);
                    PCSel   = (dec_jump || (dec_branch && br_taken)) ? PC_ALU : PC_PLUS4;
                end
                S_TRAP: begin
                    trap    = 1'b1;
                    PCWrite = 1'b1;
                    PCSel   = PC_TRAP;
                end
                default: ;
            endcase
        end
    end

    assign ir         = ir_q;
    assign instret    = instret_q;
    assign trap_cause = trap_cause_q;

endmodule
